// File: rtl/regs_cmd_arb.sv
// Round-robin arbiter that serialises N initiators onto the single ctrl_regs command port.
// Read data is routed back to the initiator that issued the read.
module regs_cmd_arb #(
  parameter int N      = 3,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      req_i,
  input  logic [2*N-1:0]    req_cmd_i,
  input  logic [8*N-1:0]    req_addr_i,
  input  logic [32*N-1:0]   req_wdata_i,
  output logic [N-1:0]      gnt_o,
  output logic [N-1:0]      rsp_vld_o,
  output logic [31:0]       rsp_data_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [1:0]        cmd_o,
  output logic [7:0]        cmd_addr_o,
  output logic [31:0]       cmd_data_o,
  input  logic [31:0]       cmd_data_i,
  output logic [1:0]        state_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;
  localparam logic [1:0] CMD_ERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      cmd_q;
  logic [7:0]      addr_q;
  logic [31:0]     data_q;
  logic [N-1:0]    rsp_vld_q;
  logic [31:0]     rsp_data_q;
  logic            err_q;

  // Handshake: an initiator holds req_i[k] and its payload stable until gnt_o[k];
  // the payload is consumed in the gnt_o[k] cycle and req_i[k] may drop afterwards.
  logic [1:0]      sl_cmd   [N];
  logic [7:0]      sl_addr  [N];
  logic [31:0]     sl_wdata [N];

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign sl_cmd[k]   = req_cmd_i[2*k +: 2];
    assign sl_addr[k]  = req_addr_i[8*k +: 8];
    assign sl_wdata[k] = req_wdata_i[32*k +: 32];
  end

  logic            sel_vld;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   srch_idx;
  logic [1:0]      sel_cmd;
  logic [7:0]      sel_addr;
  logic [31:0]     sel_wdata;
  logic            arb_en;

  // Search begins one past the last winner so every requester is reached within N slots.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    srch_idx = '0;
    for (int i = 1; i <= N; i++) begin
      srch_idx = PW'((int'(ptr_q) + i) % N);
      if (!sel_vld && req_i[srch_idx]) begin
        sel_vld = 1'b1;
        sel_idx = srch_idx;
      end
    end
  end

  assign sel_cmd   = sl_cmd[sel_idx];
  assign sel_addr  = sl_addr[sel_idx];
  assign sel_wdata = sl_wdata[sel_idx];
  assign arb_en    = (state_q == S_IDLE) && !rst_i;

  always_comb begin
    gnt_o = '0;
    if (arb_en && sel_vld) begin
      gnt_o[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= PW'(N - 1);
      owner_q    <= '0;
      cnt_q      <= '0;
      cmd_q      <= CMD_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_vld_q <= '0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            ptr_q <= sel_idx;
            case (sel_cmd)
              CMD_WR, CMD_RD: begin
                cmd_q   <= sel_cmd;
                addr_q  <= sel_addr;
                data_q  <= (sel_cmd == CMD_WR) ? sel_wdata : 32'h0;
                owner_q <= sel_idx;
                state_q <= S_ISSUE;
              end
              CMD_ERR: err_q <= 1'b1;
              default: ;
            endcase
          end
        end
        S_ISSUE: begin
          cmd_q  <= CMD_IDLE;
          addr_q <= '0;
          data_q <= '0;
          if (cmd_q == CMD_RD) begin
            cnt_q   <= CW'(RD_LAT - 1);
            state_q <= S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_data_q <= cmd_data_i;
            rsp_vld_q  <= {{(N-1){1'b0}}, 1'b1} << owner_q;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_vld_o  = rsp_vld_q;
  assign rsp_data_o = rsp_data_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != S_IDLE);
  assign cmd_o      = cmd_q;
  assign cmd_addr_o = addr_q;
  assign cmd_data_o = data_q;
  assign state_o    = state_q;

endmodule

// File: doc/regs_cmd_arb.md
# regs_cmd_arb

Round-robin arbiter and sequencer that lets N initiators share the single command port of `ctrl_regs`. Each initiator uses a request/grant handshake. The arbiter drives one IDLE/RD/WR command at a time onto `ctrl_regs` (2'b00/2'b01/2'b10), waits out the read latency, and returns read data to the initiator that issued the read. It sits between the stimulus/initiator layer and `ctrl_regs` inside `tb` and the register subsystem.

## Interface
- `N`, 3: number of initiators (2..8).
- `RD_LAT`, 1: cycles from the cycle RD is driven on `cmd_o` to the cycle `cmd_data_i` holds valid data (1..4).
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in N: per-initiator request. Held with its payload until granted.
- `req_cmd_i` in 2*N: slice k is initiator k's command.
- `req_addr_i` in 8*N: slice k is the register address.
- `req_wdata_i` in 32*N: slice k is the write data.
- `gnt_o` out N: one-hot, one-cycle grant. The payload is accepted in the cycle `gnt_o[k]` is high.
- `rsp_vld_o` out N: one-cycle pulse marking read data valid for initiator k.
- `rsp_data_o` out 32: read data, valid while any `rsp_vld_o` bit is high.
- `err_o` out 1: one-cycle pulse when a granted request carries cmd 2'b11.
- `busy_o` out 1: high in the ISSUE and WAIT states.
- `cmd_o` out 2: to `ctrl_regs` `cmd_i`.
- `cmd_addr_o` out 8: to `ctrl_regs` `cmd_addr_i`.
- `cmd_data_o` out 32: to `ctrl_regs` `cmd_data_i`.
- `cmd_data_i` in 32: from `ctrl_regs` `cmd_data_o`.

## Operation
- **States:** IDLE, ISSUE, WAIT.
- **Arbitration:**
  - Happens only in IDLE with `rst_i`=0.
  - Search starts at `(ptr+1) mod N` and selects the first k with `req_i[k]`=1.
  - `gnt_o[k]` is combinational in that cycle. `ptr` becomes k at the edge.
  - `ptr` resets to N-1, so initiator 0 wins first.
- **Granted WR or RD:**
  - At the edge, register `cmd_o`/`cmd_addr_o` from slice k.
  - `cmd_data_o` takes `req_wdata_i` slice k for WR, 0 for RD.
  - Latch `owner`=k and go to ISSUE.
- **Granted 2'b00:**
  - Grant is consumed, no bus operation, no response, stay in IDLE.
- **Granted 2'b11:**
  - Grant is consumed, no bus operation.
  - `err_o`=1 in the following cycle. Stay in IDLE.
- **ISSUE** (command visible on `cmd_o` for exactly this cycle):
  - At its end, `cmd_o`/`cmd_addr_o`/`cmd_data_o` return to 0 (IDLE).
  - WR goes to IDLE.
  - RD loads `cnt`=RD_LAT-1 and goes to WAIT.
- **WAIT:**
  - While `cnt`≠0, decrement.
  - When `cnt`=0, capture `cmd_data_i` into `rsp_data_o`, set `rsp_vld_o[owner]`=1 for the next cycle, and go to IDLE.
- `rsp_data_o` holds its value until the next read capture.
- Requests arriving while busy wait. `gnt_o` is 0 outside IDLE.
- `req_i` withdrawn before grant: legal, nothing is issued.

## Timing
- **Reset values:**
  - `cmd_o`=2'b00, `cmd_addr_o`=0, `cmd_data_o`=0.
  - `gnt_o`=0, `rsp_vld_o`=0, `rsp_data_o`=0, `err_o`=0, `busy_o`=0.
  - State IDLE, `ptr`=N-1, `cnt`=0.
  - `gnt_o` is forced 0 while `rst_i`=1.
- **WR:**
  - Grant in cycle t, `cmd_o`=WR in t+1, IDLE in t+2.
  - Next grant possible in t+2, giving 1 write per 2 cycles maximum.
- **RD:**
  - Grant in t, `cmd_o`=RD in t+1.
  - Data sampled at the end of cycle t+1+RD_LAT.
  - `rsp_vld_o` high in t+2+RD_LAT; the next grant is possible in that same cycle.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Fairness: a continuously requesting initiator waits at most N-1 other grants.
- **Wrap-around:** after `ptr`=N-1, the search starts at 0.
- **Reset mid-operation** (ISSUE or WAIT):
  - Next edge forces reset values.
  - A pending read is dropped and no `rsp_vld_o` is generated.
  - `ptr` returns to N-1.

## Test plan
- **Reset:** assert `rst_i` 3 cycles with `req_i`=3'b111 → `gnt_o`=0, `cmd_o`=0, `busy_o`=0 throughout. After release, first grant goes to initiator 0.
- **Single write then read:**
  - Init 1 writes addr 0x00 data 0x0000_FFFF → `cmd_o`=WR, addr 0x00, data 0x0000_FFFF for one cycle.
  - Init 1 then reads 0x00 → `rsp_vld_o`=3'b010 with `rsp_data_o` equal to the `ctrl_regs` read value, RD_LAT+2 cycles after grant.
- **Round-robin:** all three request RD of 0x10/0x14/0x18 continuously → grant order 0,1,2,0. Each `rsp_vld_o` pulse goes to the matching owner, with addresses 0x10/0x14/0x18 in sequence.
- **Back-to-back writes:** init 2 requests 4 writes → grants exactly every 2 cycles, `cmd_o` alternates WR/IDLE.
- **Illegal command:** init 0 issues cmd 2'b11 → `gnt_o[0]` pulses, `err_o` pulses the next cycle, `cmd_o` stays 0.
- **Reset during WAIT:** RD_LAT=3, assert `rst_i` one cycle after ISSUE → no `rsp_vld_o`, all outputs at reset values.
